// File: rtl/fp_add_scheduler.sv
// Round-robin scheduler sharing one pipelined FP adder among N_REQ requesters.
// Credit-based result FIFO returns each result, in issue order, to the requester that owns it.
module fp_add_scheduler #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_a,
  input  logic [32*N_REQ-1:0]  req_b,
  output logic [N_REQ-1:0]     rsp_valid,
  input  logic [N_REQ-1:0]     rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [3:0]           rsp_flags,
  output logic [31:0]          add_a,
  output logic [31:0]          add_b,
  input  logic [31:0]          add_result,
  input  logic [3:0]           add_flags,
  output logic                 busy
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned LW = $clog2(LAT + 1);
  localparam int unsigned EW = IW + 36;

  logic [IW-1:0] r_rr_ptr;
  logic [LAT-1:0] r_tag_vld;
  logic [IW-1:0] r_tag_id [LAT];
  logic [LW-1:0] r_inflight_count;
  logic [CW-1:0] r_fifo_count;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [EW-1:0] r_mem [DEPTH];

  logic          w_credit_ok;
  logic          w_found;
  logic [IW-1:0] w_gnt_idx;
  logic [IW-1:0] w_cand;
  logic          w_xfer;
  logic          w_wr;
  logic          w_pop;
  logic          w_empty;
  logic [EW-1:0] w_head;
  logic [IW-1:0] w_head_id;

  // Pops do not free credit until the count register updates.
  assign w_credit_ok = (32'(r_fifo_count) + 32'(r_inflight_count)) < DEPTH;

  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      w_cand = IW'((int'(r_rr_ptr) + k) % int'(N_REQ));
      if (w_credit_ok && !w_found && req_valid[w_cand]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (w_found && rst_n) req_ready[w_gnt_idx] = 1'b1;
  end

  assign w_xfer = |req_ready;
  assign add_a  = w_xfer ? req_a[32*w_gnt_idx +: 32] : 32'h0;
  assign add_b  = w_xfer ? req_b[32*w_gnt_idx +: 32] : 32'h0;

  assign w_wr      = r_tag_vld[LAT-1];
  assign w_empty   = (r_fifo_count == '0);
  assign w_head    = r_mem[r_rd_ptr];
  assign w_head_id = w_head[EW-1 -: IW];
  assign w_pop     = !w_empty && rsp_ready[w_head_id];

  always_comb begin
    rsp_valid = '0;
    if (!w_empty) rsp_valid[w_head_id] = 1'b1;
  end

  assign rsp_data  = w_empty ? 32'h0 : w_head[35:4];
  assign rsp_flags = w_empty ? 4'h0 : w_head[3:0];
  assign busy      = (r_fifo_count != '0) || (r_inflight_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr         <= IW'(N_REQ - 1);
      r_tag_vld        <= '0;
      r_inflight_count <= '0;
      for (int i = 0; i < int'(LAT); i++) r_tag_id[i] <= '0;
    end else begin
      if (w_xfer) r_rr_ptr <= w_gnt_idx;
      r_tag_vld[0] <= w_xfer;
      r_tag_id[0]  <= w_gnt_idx;
      for (int i = 1; i < int'(LAT); i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_id[i]  <= r_tag_id[i-1];
      end
      case ({w_xfer, w_wr})
        2'b10:   r_inflight_count <= r_inflight_count + LW'(1);
        2'b01:   r_inflight_count <= r_inflight_count - LW'(1);
        default: r_inflight_count <= r_inflight_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_count <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= (32'(r_wr_ptr) == DEPTH - 1) ? '0 : r_wr_ptr + PW'(1);
      if (w_pop) r_rd_ptr <= (32'(r_rd_ptr) == DEPTH - 1) ? '0 : r_rd_ptr + PW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_fifo_count <= r_fifo_count + CW'(1);
        2'b01:   r_fifo_count <= r_fifo_count - CW'(1);
        default: r_fifo_count <= r_fifo_count;
      endcase
    end
  end

  // Storage only; validity is carried by the reset pointers and count.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {r_tag_id[LAT-1], add_result, add_flags};
  end

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Randomised bench for fp_add_scheduler with a stub adder and a queue-based scoreboard.
// The model tracks outstanding operations, the last grant and each result's due cycle.
module tb_fp_add_scheduler;
  localparam int N = 4;
  localparam int LAT = 2;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [32*N-1:0] req_a, req_b;
  logic [31:0]     rsp_data, add_a, add_b, add_result;
  logic [3:0]      rsp_flags, add_flags;
  logic            busy;

  always #5 clk = ~clk;

  fp_add_scheduler #(.N_REQ(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .add_a(add_a), .add_b(add_b),
    .add_result(add_result), .add_flags(add_flags), .busy(busy)
  );

  // Stand-in adder: known answers for the directed cases, an arbitrary mix otherwise.
  function automatic logic [35:0] fadd(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return {32'h40400000, 4'h0};
    if (a[30:0] == 31'h7F800000 && b[30:0] == 31'h7F800000 && a[31] != b[31])
      return {32'h7FC00001, 4'b1100};
    return {a + {b[15:0], b[31:16]}, a[3:0] ^ b[7:4]};
  endfunction

  logic [35:0] pipe [LAT];
  initial for (int i = 0; i < LAT; i++) pipe[i] = '0;
  always @(posedge clk) begin
    pipe[0] <= fadd(add_a, add_b);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign add_result = pipe[LAT-1][35:4];
  assign add_flags  = pipe[LAT-1][3:0];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {
    int          id;
    logic [35:0] res;
    int          due;
  } ent_t;

  ent_t sb[$];
  int   gnt_log[$];
  int   cyc = 0;
  int   m_last = N - 1;
  int   m_out = 0;

  // Monitor and reference model: evaluated once per cycle, away from the rising edge.
  always @(negedge clk) begin
    int gid;
    int idx;
    logic [N-1:0] exp_gnt, exp_rv;
    logic [31:0] ea, eb;
    cyc++;
    if (!rst_n) begin
      chk("reset_hs", {req_ready, rsp_valid, busy}, '0);
      chk("reset_data", {add_a, add_b, rsp_data, rsp_flags}, '0);
      sb.delete();
      m_last = N - 1;
      m_out  = 0;
    end else begin
      gid = -1;
      exp_gnt = '0;
      if (m_out < DEPTH) begin
        for (int k = 1; k <= N; k++) begin
          idx = (m_last + k) % N;
          if (gid < 0 && req_valid[idx]) gid = idx;
        end
      end
      if (gid >= 0) exp_gnt[gid] = 1'b1;
      chk("grant", req_ready, exp_gnt);
      ea = (gid >= 0) ? req_a[32*gid +: 32] : 32'h0;
      eb = (gid >= 0) ? req_b[32*gid +: 32] : 32'h0;
      chk("adder_operands", {add_a, add_b}, {ea, eb});
      chk("busy", busy, m_out != 0);
      if (sb.size() > 0 && cyc >= sb[0].due) begin
        exp_rv = '0;
        exp_rv[sb[0].id] = 1'b1;
        chk("response", {rsp_valid, rsp_data, rsp_flags}, {exp_rv, sb[0].res});
        if (rsp_ready[sb[0].id]) begin
          void'(sb.pop_front());
          m_out--;
        end
      end else begin
        chk("rsp_valid_idle", rsp_valid, '0);
      end
      if (gid >= 0) begin
        sb.push_back('{gid, fadd(ea, eb), cyc + LAT + 1});
        m_out++;
        m_last = gid;
        gnt_log.push_back(gid);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = $urandom;
      req_b[32*i +: 32] = $urandom;
    end
  endtask

  // Raise one request, wait for its grant, drop it right after the accepting edge.
  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b);
    bit ok;
    ok = 1'b0;
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
    req_valid[id] = 1'b1;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (req_ready[id]) ok = 1'b1;
      else tick();
    end
    if (!ok) chk("grant_timeout", 0, 1);
    tick();
    req_valid[id] = 1'b0;
  endtask

  task automatic single(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ed, input logic [3:0] ef);
    logic [N-1:0] ev;
    ev = '0;
    ev[id] = 1'b1;
    issue(id, a, b);
    repeat (LAT) @(negedge clk);
    chk("latency_early", rsp_valid, '0);
    @(negedge clk);
    chk("latency_result", {rsp_valid, rsp_data, rsp_flags}, {ev, ed, ef});
    tick();
  endtask

  initial begin
    int cnt;
    int st;
    req_valid = '0;
    rsp_ready = '0;
    req_a = '0;
    req_b = '0;
    tick(3);
    rst_n = 1'b1;
    tick();

    rsp_ready = '1;
    single(0, 32'h3F800000, 32'h40000000, 32'h40400000, 4'h0);
    tick(3);

    gnt_log.delete();
    st = (m_last + 1) % N;
    req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      tick();
    end
    req_valid = '0;
    chk("fair_count", gnt_log.size(), 8);
    for (int i = 0; i < 8 && i < gnt_log.size(); i++) chk("fair_order", gnt_log[i], (st + i) % N);
    tick(6);

    rsp_ready = '0;
    req_valid = 4'b0100;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      rand_ops();
      @(negedge clk);
      if (req_ready[2]) cnt++;
      tick();
    end
    chk("bp_transfers", cnt, 4);
    chk("bp_stalled", req_ready, '0);
    rsp_ready = 4'b0100;
    tick();
    rsp_ready = '0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (req_ready[2]) cnt++;
      tick();
    end
    chk("bp_one_more", cnt, 1);
    req_valid = '0;
    rsp_ready = '1;
    tick(8);

    single(1, 32'h7F800000, 32'hFF800000, 32'h7FC00001, 4'b1100);
    tick(3);

    rand_ops();
    req_valid = 4'b0011;
    cnt = 0;
    for (int t = 0; t < 20 && cnt < 2; t++) begin
      @(negedge clk);
      if (|req_ready) cnt++;
      tick();
    end
    chk("rst_two_issued", cnt, 2);
    req_valid = '0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_quiet", {rsp_valid, busy}, '0);
    tick();
    rst_n = 1'b1;
    tick(6);
    req_valid = '1;
    @(negedge clk);
    chk("rst_first_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    tick(6);

    rsp_ready = '0;
    for (int i = 0; i < 3; i++) issue(i, $urandom, $urandom);
    tick(4);
    issue(3, $urandom, $urandom);
    tick(LAT - 1);
    rsp_ready = '1;
    tick();
    rsp_ready = '0;
    req_valid = 4'b0001;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (req_ready[0]) cnt++;
      tick();
    end
    chk("wr_pop_credit", cnt, 1);
    req_valid = '0;
    rsp_ready = '1;
    tick(10);
    chk("drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
